// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: RV32I width codes,
// FSM encoding, latched request record and byte-lane helpers.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] data;
    } lsu_req_t;

    // Byte lanes touched by an access of the given width at byte offset off.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] base;
        case (funct3[1:0])
            2'b00:   base = LANE_B;
            2'b01:   base = LANE_H;
            default: base = LANE_W;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] align_addr(input logic [2:0] funct3, input logic [31:0] addr);
        case (funct3[1:0])
            2'b01:   return {addr[31:1], 1'b0};
            2'b10:   return {addr[31:2], 2'b00};
            default: return addr;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response channel of the load/store unit.
interface load_store_unit_if;
    logic        request_valid;
    logic        request_ready;
    logic        request_write;
    logic [2:0]  request_funct3;
    logic [31:0] request_address;
    logic [31:0] request_data;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] response_data;
    logic        response_fault;

    modport master (
        output request_valid, request_write, request_funct3, request_address, request_data,
        output response_ready,
        input  request_ready, response_valid, response_data, response_fault
    );

    modport slave (
        input  request_valid, request_write, request_funct3, request_address, request_data,
        input  response_ready,
        output request_ready, response_valid, response_data, response_fault
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data and merges sub-word
// store data into a full RAM word (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);
    logic [31:0] shifted;
    logic [31:0] store_shifted;
    logic [3:0]  mask;

    assign shifted       = word >> {offset, 3'b000};
    assign store_shifted = store_data << {offset, 3'b000};
    assign mask          = lane_mask(funct3, offset);

    always_comb begin
        load_value = '0;
        case (funct3)
            LSU_B:   load_value = {{24{shifted[7]}}, shifted[7:0]};
            LSU_BU:  load_value = {24'h0, shifted[7:0]};
            LSU_H:   load_value = {{16{shifted[15]}}, shifted[15:0]};
            LSU_HU:  load_value = {16'h0, shifted[15:0]};
            LSU_W:   load_value = word;
            default: load_value = '0;
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign store_word[8*i +: 8] = mask[i] ? store_shifted[8*i +: 8] : word[8*i +: 8];
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide RAM; sub-word stores are done as
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int SIZE_WORDS = 32
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.slave   bus,
    output logic [31:0]        ram_address,
    output logic [31:0]        ram_input_data,
    output logic               ram_should_write,
    input  logic [31:0]        ram_output_data
);
    localparam logic [31:0] ADDR_LIMIT = 32'(SIZE_WORDS * 4);

    lsu_state_t  state, state_next;
    lsu_req_t    req_q, req_in;
    logic [31:0] word_q, resp_data_q;
    logic        resp_fault_q;
    logic [31:0] align_word, load_value, store_word;
    logic        funct3_legal, out_of_range, fault;

    always_comb begin
        funct3_legal = 1'b0;
        case (bus.request_funct3)
            LSU_B, LSU_H, LSU_W: funct3_legal = 1'b1;
            LSU_BU, LSU_HU:      funct3_legal = !bus.request_write;
            default:             funct3_legal = 1'b0;
        endcase
    end

    assign out_of_range = bus.request_address >= ADDR_LIMIT;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (bus.request_funct3[1:0] == 2'b01 && bus.request_address[0]) ||
                        (bus.request_funct3[1:0] == 2'b10 && bus.request_address[1:0] != 2'b00);
    assign fault = !funct3_legal || misaligned || out_of_range;
    assign req_in = '{write: bus.request_write, funct3: bus.request_funct3,
                      addr: bus.request_address, data: bus.request_data};
`else
    // Misaligned accesses silently round down to their natural alignment.
    assign fault = !funct3_legal || out_of_range;
    assign req_in = '{write: bus.request_write, funct3: bus.request_funct3,
                      addr: align_addr(bus.request_funct3, bus.request_address),
                      data: bus.request_data};
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.request_valid) begin
                if (fault)
                    state_next = RESP;
                else if (bus.request_write && bus.request_funct3 == LSU_W)
                    state_next = WRITE;
                else
                    state_next = READ;
            end
            READ:    state_next = req_q.write ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    if (bus.response_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            req_q        <= '0;
            word_q       <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (bus.request_valid) begin
                    req_q        <= req_in;
                    resp_data_q  <= '0;
                    resp_fault_q <= fault;
                end
                READ: begin
                    word_q <= ram_output_data;
                    if (!req_q.write) resp_data_q <= load_value;
                end
                default: ;
            endcase
        end
    end

    // READ works on the live RAM word; WRITE merges into the captured copy.
    assign align_word = (state == READ) ? ram_output_data : word_q;

    lsu_align u_align (
        .word       (align_word),
        .offset     (req_q.addr[1:0]),
        .funct3     (req_q.funct3),
        .store_data (req_q.data),
        .load_value (load_value),
        .store_word (store_word)
    );

    assign ram_address      = {req_q.addr[31:2], 2'b00};
    assign ram_input_data   = (state == WRITE) ? store_word : '0;
    assign ram_should_write = (state == WRITE) && !reset;

    assign bus.request_ready  = (state == IDLE);
    assign bus.response_valid = (state == RESP);
    assign bus.response_data  = resp_data_q;
    assign bus.response_fault = resp_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, hand-written corner sequences and
// random traffic scored against an arithmetic memory model.
module tb_load_store_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ram_address, ram_input_data, ram_output_data;
    logic        ram_should_write;

    load_store_unit_if bus();

    load_store_unit #(.SIZE_WORDS(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .ram_address      (ram_address),
        .ram_input_data   (ram_input_data),
        .ram_should_write (ram_should_write),
        .ram_output_data  (ram_output_data)
    );

    always #5 clock = ~clock;

    // RAM: combinational read, negedge commit; preload port shares the process
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    int          wr_total = 0;
    logic        pre_we = 1'b0;
    logic [4:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    assign ram_output_data = (ram_address < 32'd128) ? mem[ram_address[6:2]] : 32'h0;

    always @(negedge clock) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (ram_should_write) begin
            if (ram_address < 32'd128) mem[ram_address[6:2]] <= ram_input_data;
            wr_total <= wr_total + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_idx = 5'(idx);
        pre_val = val;
        pre_we  = 1'b1;
        ref_mem[idx] = val;
        @(negedge clock);
        #1 pre_we = 1'b0;
    endtask

    // Reference: what an access must return, computed from width/alignment rules
    task automatic ref_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, output logic [31:0] e_data,
                              output logic e_fault, output int e_lat, output int e_wr);
        int unsigned size, sh;
        logic        legal, mis, oor, flt;
        logic [31:0] a, w, m;
        size  = 1 << f3[1:0];
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (addr % size) != 0;
        oor   = addr >= 32'd128;
`ifdef LSU_MISALIGN_TRAP_EN
        flt = !legal || mis || oor;
        a   = addr;
`else
        flt = !legal || oor;
        a   = addr - (addr % size);
`endif
        e_data = 0; e_fault = flt; e_lat = 1; e_wr = 0;
        if (!flt) begin
            w  = ref_mem[a / 4];
            sh = (a % 4) * 8;
            m  = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
            if (!wr) begin
                e_data = (w >> sh) & m;
                if (!f3[2] && size < 4 && e_data[8*size-1]) e_data = e_data | ~m;
                e_lat = 2;
            end else begin
                ref_mem[a / 4] = (w & ~(m << sh)) | ((data & m) << sh);
                e_lat = (size == 4) ? 2 : 3;
                e_wr  = 1;
            end
        end
    endtask

    // Issue one request from IDLE and collect response, its latency and RAM writes.
    task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int hold,
                           output logic [31:0] got_data, output logic got_fault,
                           output int got_lat, output int got_wr, output int wr_at);
        bus.request_valid   = 1'b1;
        bus.request_write   = wr;
        bus.request_funct3  = f3;
        bus.request_address = addr;
        bus.request_data    = data;
        @(posedge clock);
        #1 bus.request_valid = 1'b0;
        got_data = '0; got_fault = 1'b0; got_lat = 0; got_wr = 0; wr_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (ram_should_write) begin got_wr++; wr_at = k; end
            if (bus.response_valid) begin
                got_lat   = k;
                got_data  = bus.response_data;
                got_fault = bus.response_fault;
                break;
            end
        end
        if (got_lat != 0) begin
            repeat (hold) @(negedge clock);
            bus.response_ready = 1'b1;
            @(posedge clock);
            #1 bus.response_ready = 1'b0;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] gd, ed;
        logic        gf, ef;
        int          gl, gw, wa, el, ew, snap;

        bus.request_valid = 1'b0; bus.request_write = 1'b0; bus.request_funct3 = '0;
        bus.request_address = '0; bus.request_data = '0; bus.response_ready = 1'b0;

        for (int i = 0; i < 32; i++) preload(i, $urandom);
        preload(0, 32'h1234_C0DE);
        preload(4, 32'h8899_AABB);
        preload(8, 32'h1122_3344);

        chk("reset_resp_valid", 32'(bus.response_valid), 32'h0);
        chk("reset_req_ready", 32'(bus.request_ready), 32'h1);
        chk("reset_resp_data", bus.response_data, 32'h0);
        chk("reset_resp_fault", 32'(bus.response_fault), 32'h0);
        chk("reset_ram_we", 32'(ram_should_write), 32'h0);
        chk("reset_ram_wdata", ram_input_data, 32'h0);
        chk("reset_ram_addr", ram_address, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        tbl[0]  = '{1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 0};
        tbl[1]  = '{1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, 2, 0};
        tbl[2]  = '{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8899, 1'b0, 2, 0};
        tbl[3]  = '{1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8899, 1'b0, 2, 0};
        tbl[4]  = '{1'b1, 3'b000, 32'h22, 32'hEE, 32'h0, 1'b0, 3, 1};
        tbl[5]  = '{1'b0, 3'b010, 32'h20, 32'h0, 32'h11EE_3344, 1'b0, 2, 0};
        tbl[6]  = '{1'b1, 3'b010, 32'h7C, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1};
        tbl[7]  = '{1'b0, 3'b010, 32'h7C, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0};
        tbl[8]  = '{1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 1'b1, 1, 0};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[9]  = '{1'b0, 3'b001, 32'h01, 32'h0, 32'h0, 1'b1, 1, 0};
`else
        tbl[9]  = '{1'b0, 3'b001, 32'h01, 32'h0, 32'hFFFF_C0DE, 1'b0, 2, 0};
`endif
        tbl[10] = '{1'b1, 3'b100, 32'h04, 32'h55, 32'h0, 1'b1, 1, 0};
        tbl[11] = '{1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0};

        for (int i = 0; i < 12; i++) begin
            ref_access(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].data, ed, ef, el, ew);
            run_req(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].data, i % 3, gd, gf, gl, gw, wa);
            chk($sformatf("vec%0d_data", i), gd, tbl[i].exp_data);
            chk($sformatf("vec%0d_fault", i), 32'(gf), 32'(tbl[i].exp_fault));
            chk($sformatf("vec%0d_latency", i), 32'(gl), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_writes", i), 32'(gw), 32'(tbl[i].exp_wr));
            if (tbl[i].exp_wr != 0) chk($sformatf("vec%0d_write_cycle", i), 32'(wa), 32'(tbl[i].exp_lat - 1));
        end

        // Backpressure: response must hold while response_ready stays low
        bus.request_valid = 1'b1; bus.request_write = 1'b0; bus.request_funct3 = 3'b000;
        bus.request_address = 32'h11; bus.request_data = '0;
        @(posedge clock);
        #1 bus.request_valid = 1'b0;
        gl = 0;
        for (int k = 1; k <= 10 && gl == 0; k++) begin
            @(negedge clock);
            if (bus.response_valid) gl = k;
        end
        chk("bp_latency", 32'(gl), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_valid_held", 32'(bus.response_valid), 32'h1);
            chk("bp_data_held", bus.response_data, 32'hFFFF_FFAA);
            chk("bp_req_ready_low", 32'(bus.request_ready), 32'h0);
        end
        bus.response_ready = 1'b1;
        @(posedge clock);
        #1 bus.response_ready = 1'b0;
        @(negedge clock);
        chk("bp_released_valid", 32'(bus.response_valid), 32'h0);
        chk("bp_released_ready", 32'(bus.request_ready), 32'h1);

        // Reset during the WRITE cycle of an SB must suppress the commit
        snap = wr_total;
        bus.request_valid = 1'b1; bus.request_write = 1'b1; bus.request_funct3 = 3'b000;
        bus.request_address = 32'h21; bus.request_data = 32'h55;
        @(posedge clock);
        #1 bus.request_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_write_suppressed", 32'(ram_should_write), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_mem_unchanged", mem[8], 32'h11EE_3344);
        chk("rst_no_write", 32'(wr_total), 32'(snap));
        chk("rst_resp_valid", 32'(bus.response_valid), 32'h0);
        chk("rst_idle", 32'(bus.request_ready), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] addr, data;
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, 135);
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << f3[1:0]) - 1);
            data = $urandom;
            snap = wr_total;
            ref_access(wr, f3, addr, data, ed, ef, el, ew);
            run_req(wr, f3, addr, data, $urandom_range(0, 2), gd, gf, gl, gw, wa);
            chk($sformatf("rnd%0d_data", i), gd, ed);
            chk($sformatf("rnd%0d_fault", i), 32'(gf), 32'(ef));
            chk($sformatf("rnd%0d_latency", i), 32'(gl), 32'(el));
            chk($sformatf("rnd%0d_writes", i), 32'(wr_total - snap), 32'(ew));
        end

        for (int i = 0; i < 32; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
